// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN datapath blocks.
package cnn_pkg;

  localparam int unsigned DEF_DATA_W = 16;

  typedef enum logic [1:0] {StIdle, StRun, StDone, StHold} pool_state_t;

  function automatic logic [DEF_DATA_W-1:0] smax(input logic [DEF_DATA_W-1:0] a,
                                                 input logic [DEF_DATA_W-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Simple dual-port line buffer: synchronous write, registered read, no reset.
module pool_line_buf #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/maxpool_2x2.sv
// Streaming 2x2 / stride-2 signed max-pool; even-row horizontal maxima are parked in a
// half-width line buffer and merged when the matching odd row arrives.
module maxpool_2x2
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned MAX_W  = 256,
  parameter int unsigned DIM_W  = 10,
  parameter int unsigned CH_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pool_en,
  output logic              pool_done,
  input  logic [DIM_W-1:0]  cfg_width,
  input  logic [DIM_W-1:0]  cfg_height,
  input  logic [CH_W-1:0]   cfg_chan,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              cfg_err
);

  localparam int unsigned LbDepth = MAX_W / 2;
  localparam int unsigned LbAw    = $clog2(LbDepth);

  pool_state_t       state_q, state_d;
  logic [DIM_W-1:0]  w_q, w_d, h_q, h_d, col_q, col_d, row_q, row_d;
  logic [CH_W-1:0]   c_q, c_d, ch_q, ch_d;
  logic [DATA_W-1:0] hmax_q, hmax_d, out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic              cfg_err_q, cfg_err_d, in_done_q, in_done_d;

  logic              lb_we, lb_re;
  logic [DATA_W-1:0] lb_wdata, lb_rdata;
  logic [LbAw-1:0]   lb_addr;

  logic fire_in, fire_out, cfg_bad, col_end, row_end, ch_end, col_ok, row_ok;
  logic [DIM_W-1:0] w_even_m1, h_even_m1;

  assign in_ready  = (state_q == StRun) && !in_done_q && (!out_valid_q || out_ready);
  assign fire_in   = in_valid && in_ready;
  assign fire_out  = out_valid_q && out_ready;
  assign cfg_bad   = (cfg_width < DIM_W'(2)) || (cfg_height < DIM_W'(2)) ||
                     (cfg_chan == '0) || (cfg_width > DIM_W'(MAX_W));
  assign col_end   = (col_q == w_q - DIM_W'(1));
  assign row_end   = (row_q == h_q - DIM_W'(1));
  assign ch_end    = (ch_q == c_q - CH_W'(1));
  // A pixel belongs to a full 2x2 window only if its odd partner index exists.
  assign col_ok    = {col_q[DIM_W-1:1], 1'b1} < w_q;
  assign row_ok    = {row_q[DIM_W-1:1], 1'b1} < h_q;
  assign w_even_m1 = {w_q[DIM_W-1:1], 1'b0} - DIM_W'(1);
  assign h_even_m1 = {h_q[DIM_W-1:1], 1'b0} - DIM_W'(1);
  assign lb_addr   = col_q[LbAw:1];
  assign lb_wdata  = smax(hmax_q, in_data);

  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    h_d         = h_q;
    c_d         = c_q;
    col_d       = col_q;
    row_d       = row_q;
    ch_d        = ch_q;
    hmax_d      = hmax_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    cfg_err_d   = cfg_err_q;
    in_done_d   = in_done_q;
    lb_we       = 1'b0;
    lb_re       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pool_en) begin
          w_d         = cfg_width;
          h_d         = cfg_height;
          c_d         = cfg_chan;
          col_d       = '0;
          row_d       = '0;
          ch_d        = '0;
          in_done_d   = 1'b0;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          cfg_err_d   = cfg_bad;
          state_d     = cfg_bad ? StDone : StRun;
        end
      end
      StRun: begin
        if (!pool_en) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = StIdle;
        end else begin
          if (fire_out) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end
          if (fire_in) begin
            if (col_end) begin
              col_d = '0;
              if (row_end) begin
                row_d = '0;
                ch_d  = ch_q + CH_W'(1);
                if (ch_end) in_done_d = 1'b1;
              end else begin
                row_d = row_q + DIM_W'(1);
              end
            end else begin
              col_d = col_q + DIM_W'(1);
            end
            if (col_ok && row_ok) begin
              if (!col_q[0]) begin
                hmax_d = in_data;
                lb_re  = row_q[0];
              end else if (!row_q[0]) begin
                lb_we = 1'b1;
              end else begin
                out_data_d  = smax(smax(hmax_q, in_data), lb_rdata);
                out_valid_d = 1'b1;
                out_last_d  = (col_q == w_even_m1) && (row_q == h_even_m1);
              end
            end
          end
          // No loads can follow the last input, so the final out fire ends the job.
          if (in_done_q && (!out_valid_q || out_ready)) state_d = StDone;
        end
      end
      StDone: state_d = StHold;
      StHold: if (!pool_en) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      w_q         <= '0;
      h_q         <= '0;
      c_q         <= '0;
      col_q       <= '0;
      row_q       <= '0;
      ch_q        <= '0;
      hmax_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
      in_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      h_q         <= h_d;
      c_q         <= c_d;
      col_q       <= col_d;
      row_q       <= row_d;
      ch_q        <= ch_d;
      hmax_q      <= hmax_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      cfg_err_q   <= cfg_err_d;
      in_done_q   <= in_done_d;
    end
  end

  pool_line_buf #(
    .DATA_W(DATA_W),
    .DEPTH (LbDepth),
    .AW    (LbAw)
  ) u_line_buf (
    .clk    (clk),
    .wr_en  (lb_we),
    .wr_addr(lb_addr),
    .wr_data(lb_wdata),
    .rd_en  (lb_re),
    .rd_addr(lb_addr),
    .rd_data(lb_rdata)
  );

  assign pool_done = (state_q == StDone);
  assign busy      = (state_q == StRun);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_maxpool_2x2.sv
// Scoreboard bench for maxpool_2x2: directed jobs, expected pooled pixels queued at issue.
module tb_maxpool_2x2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pool_en = 1'b0;
  logic        pool_done;
  logic [9:0]  cfg_width = '0;
  logic [9:0]  cfg_height = '0;
  logic [7:0]  cfg_chan = '0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;
  logic        busy;
  logic        cfg_err;

  maxpool_2x2 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pool_en   (pool_en),
    .pool_done (pool_done),
    .cfg_width (cfg_width),
    .cfg_height(cfg_height),
    .cfg_chan  (cfg_chan),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] pix_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          done_count = 0;
  int          done_cyc = 0;
  int          last_fire_cyc = 0;
  int          n_in = 0;
  bit          toggle_ready = 1'b0;
  bit          stall_pend = 1'b0;
  logic [15:0] stall_data;
  logic        stall_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = toggle_ready ? ~out_ready : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every out fire, checks hold-stability on stalls.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (stall_pend) begin
        check("stall_data_stable", {16'h0, out_data}, {16'h0, stall_data});
        check("stall_last_stable", {31'h0, out_last}, {31'h0, stall_last});
      end
      if (out_ready) begin
        stall_pend = 1'b0;
        last_fire_cyc = cyc;
        if (sb.size() == 0) begin
          check("unexpected_output", {16'h0, out_data}, 32'hffff_ffff);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_data", {16'h0, out_data}, {16'h0, e.data});
          check("out_last", {31'h0, out_last}, {31'h0, e.last});
        end
      end else begin
        stall_pend = 1'b1;
        stall_data = out_data;
        stall_last = out_last;
      end
    end else begin
      stall_pend = 1'b0;
    end
    if (rst_n && pool_done) begin
      done_count++;
      done_cyc = cyc;
    end
  end

  task automatic push_exp(input logic [15:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    sb.push_back(e);
  endtask

  task automatic send(input logic [15:0] d);
    int guard;
    guard = 0;
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
    else n_in++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic start(input int w, input int h, input int c);
    cfg_width  = 10'(w);
    cfg_height = 10'(h);
    cfg_chan   = 8'(c);
    pool_en    = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic finish_job(input string name, input bit chk_timing);
    int d0;
    d0 = done_count;
    for (int i = 0; i < 500 && done_count == d0; i++) @(negedge clk);
    check({name, "_done_seen"}, 32'(done_count - d0), 32'd1);
    if (chk_timing) check({name, "_done_timing"}, 32'(done_cyc), 32'(last_fire_cyc + 1));
    @(posedge clk);
    #1;
    pool_en = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check({name, "_one_pulse"}, 32'(done_count - d0), 32'd1);
    check({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
    check({name, "_idle"}, {30'h0, busy, in_ready}, 32'd0);
  endtask

  task automatic run_job(input string name, input int w, input int h, input int c,
                         input bit rnd, input bit chk_timing);
    int n;
    n = pix_q.size();
    n_in = 0;
    start(w, h, c);
    while (pix_q.size() > 0) begin
      if (rnd && $urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      send(pix_q.pop_front());
    end
    check({name, "_inputs"}, 32'(n_in), 32'(n));
    finish_job(name, chk_timing);
  endtask

  task automatic load_4x4();
    for (int i = 1; i <= 16; i++) pix_q.push_back(16'(i));
    push_exp(16'd6, 1'b0);
    push_exp(16'd8, 1'b0);
    push_exp(16'd14, 1'b0);
    push_exp(16'd16, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    #12;
    check("reset_outputs", {16'h0, out_data},
          {26'h0, pool_done, in_ready, out_valid, out_last, busy, cfg_err} + 32'd0);
    check("reset_ctrl", {26'h0, pool_done, in_ready, out_valid, out_last, busy, cfg_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: 4x4 single plane
    load_4x4();
    run_job("t1", 4, 4, 1, 1'b0, 1'b1);

    // 2: same data, toggling out_ready and bursty in_valid
    toggle_ready = 1'b1;
    load_4x4();
    run_job("t2", 4, 4, 1, 1'b1, 1'b1);
    toggle_ready = 1'b0;

    // 3: 5x3, two planes of ramp 0..14
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 15; i++) pix_q.push_back(16'(i));
      push_exp(16'd6, 1'b0);
      push_exp(16'd8, 1'b1);
    end
    run_job("t3", 5, 3, 2, 1'b0, 1'b0);

    // 4: signed compare
    pix_q.push_back(-16'sd5);
    pix_q.push_back(-16'sd3);
    pix_q.push_back(-16'sd7);
    pix_q.push_back(-16'sd4);
    push_exp(-16'sd3, 1'b1);
    run_job("t4", 2, 2, 1, 1'b0, 1'b1);

    // 5: illegal width, then a legal job clears cfg_err
    d0 = done_count;
    cfg_width  = 10'd1;
    cfg_height = 10'd4;
    cfg_chan   = 8'd1;
    pool_en    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t5_done_pulse", {31'h0, pool_done}, 32'd1);
    check("t5_cfg_err", {31'h0, cfg_err}, 32'd1);
    check("t5_no_ready", {31'h0, in_ready}, 32'd0);
    @(negedge clk);
    check("t5_done_once", {31'h0, pool_done}, 32'd0);
    @(posedge clk);
    #1;
    pool_en = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("t5_done_count", 32'(done_count - d0), 32'd1);
    check("t5_err_sticky", {31'h0, cfg_err}, 32'd1);
    for (int i = 1; i <= 4; i++) pix_q.push_back(16'(i));
    push_exp(16'd4, 1'b1);
    start(2, 2, 1);
    check("t5_err_cleared", {31'h0, cfg_err}, 32'd0);
    n_in = 0;
    while (pix_q.size() > 0) send(pix_q.pop_front());
    finish_job("t5b", 1'b1);

    // 6: abort mid-plane, then a fresh 4x4 job
    d0 = done_count;
    start(4, 4, 1);
    for (int i = 1; i <= 5; i++) send(16'(i));
    pool_en = 1'b0;
    @(posedge clk);
    #1;
    check("t6_abort_idle", {29'h0, busy, in_ready, out_valid}, 32'd0);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check("t6_no_done", 32'(done_count - d0), 32'd0);
    load_4x4();
    run_job("t6b", 4, 4, 1, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
